// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle adder/subtractor, K bits per clock.
// Valid/ready on both sides; carry, overflow and zero flags.
module serial_add_sub #(
  parameter int W = 16,
  parameter int K = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int N  = W / K;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (W < 2 || (W % K) != 0) begin : g_bad_params
    $error("serial_add_sub: need W >= 2 and W %% K == 0");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [W-1:0]  sa;
  logic [W-1:0]  sb;
  logic [W-1:0]  res;
  logic          c;
  logic [CW-1:0] cnt;
  logic          cout_q;
  logic          ovf_q;
  logic          zero_q;

  logic [K:0]    chunk;
  logic          msb_cin;
  logic          last;
  logic [W-1:0]  res_sh;

  assign chunk = {1'b0, sa[K-1:0]}
               + {1'b0, sb[K-1:0]}
               + {{K{1'b0}}, c};

  // carry into the top bit of the chunk, recovered from its sum bit
  assign msb_cin = chunk[K-1] ^ sa[K-1] ^ sb[K-1];
  assign last    = (cnt == CW'(N - 1));
  assign res_sh  = W'({chunk[K-1:0], res} >> K);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (in_valid) state_n = RUN;
      RUN:  if (last) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sa  <= a;
            sb  <= sub ? ~b : b;
            c   <= sub | cin;
            cnt <= '0;
            res <= '0;
          end
        end
        RUN: begin
          res <= res_sh;
          sa  <= sa >> K;
          sb  <= sb >> K;
          c   <= chunk[K];
          cnt <= cnt + CW'(1);
          if (last) begin
            cout_q <= chunk[K];
            ovf_q  <= msb_cin ^ chunk[K];
            zero_q <= (res_sh == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign result = res;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed and random checks over
// several (W,K) instances of serial_add_sub.
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] a_d = '0;
  logic [31:0] b_d = '0;
  logic        cin_d = 1'b0;
  logic        sub_d = 1'b0;
  logic [4:0]  iv = '0;
  logic [4:0]  ordy = '0;
  wire  [4:0]  ir, ovl, co, of, zf;

  wire [7:0]  r0, r1, r4;
  wire [15:0] r2;
  wire [31:0] r3;
  logic [31:0] res_w [5];
  assign res_w[0] = {24'd0, r0};
  assign res_w[1] = {24'd0, r1};
  assign res_w[2] = {16'd0, r2};
  assign res_w[3] = r3;
  assign res_w[4] = {24'd0, r4};

  int wof [5] = '{8, 8, 16, 32, 8};
  int kof [5] = '{1, 4, 16, 8, 2};

  int checks = 0;
  int errors = 0;

  serial_add_sub #(.W(8), .K(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_d[7:0]), .b(b_d[7:0]),
    .cin(cin_d), .sub(sub_d),
    .out_valid(ovl[0]), .out_ready(ordy[0]),
    .result(r0), .cout(co[0]), .ovf(of[0]), .zero(zf[0]));

  serial_add_sub #(.W(8), .K(4)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_d[7:0]), .b(b_d[7:0]),
    .cin(cin_d), .sub(sub_d),
    .out_valid(ovl[1]), .out_ready(ordy[1]),
    .result(r1), .cout(co[1]), .ovf(of[1]), .zero(zf[1]));

  serial_add_sub #(.W(16), .K(16)) u2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_d[15:0]), .b(b_d[15:0]),
    .cin(cin_d), .sub(sub_d),
    .out_valid(ovl[2]), .out_ready(ordy[2]),
    .result(r2), .cout(co[2]), .ovf(of[2]), .zero(zf[2]));

  serial_add_sub #(.W(32), .K(8)) u3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[3]), .in_ready(ir[3]),
    .a(a_d), .b(b_d),
    .cin(cin_d), .sub(sub_d),
    .out_valid(ovl[3]), .out_ready(ordy[3]),
    .result(r3), .cout(co[3]), .ovf(of[3]), .zero(zf[3]));

  serial_add_sub #(.W(8), .K(2)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[4]), .in_ready(ir[4]),
    .a(a_d[7:0]), .b(b_d[7:0]),
    .cin(cin_d), .sub(sub_d),
    .out_valid(ovl[4]), .out_ready(ordy[4]),
    .result(r4), .cout(co[4]), .ovf(of[4]), .zero(zf[4]));

  // entered and left at 1ns after a rising edge
  task automatic do_op(
    input  int          i,
    input  logic [31:0] av,
    input  logic [31:0] bv,
    input  logic        ci,
    input  logic        su,
    input  int          stall,
    output int          lat,
    output logic [31:0] r,
    output logic        co_o,
    output logic        of_o,
    output logic        zf_o,
    output bit          to
  );
    int n;
    a_d = av; b_d = bv; cin_d = ci; sub_d = su;
    iv[i] = 1'b1;
    n = 0;
    while (!ir[i] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    iv[i] = 1'b0;
    lat = 0;
    while (!ovl[i] && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    to = !ovl[i];
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
    end
    r = res_w[i]; co_o = co[i]; of_o = of[i]; zf_o = zf[i];
    ordy[i] = 1'b1;
    @(posedge clk); #1;
    ordy[i] = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ir[i] !== 1'b1 || ovl[i] !== 1'b0 ||
          res_w[i] !== 32'd0 || co[i] !== 1'b0 ||
          of[i] !== 1'b0 || zf[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: rdy=%b vld=%b r=%h c=%b o=%b z=%b, need 1 0 0 0 0 0",
                 i, ir[i], ovl[i], res_w[i], co[i], of[i], zf[i]);
      end
    end
  endtask

  task automatic test_add_k1();
    int lat; logic [31:0] r; logic c, o, z; bit to;
    do_op(0, 32'h7F, 32'h01, 1'b0, 1'b0, 0, lat, r, c, o, z, to);
    checks++;
    if (to || lat !== 8) begin
      errors++;
      $display("FAIL add_k1 latency: got %0d to=%0d, need 8", lat, to);
    end
    checks++;
    if ({r, c, o, z} !== {32'h80, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_k1 value: r=%h c=%b o=%b z=%b, need 80 0 1 0", r, c, o, z);
    end
  endtask

  task automatic test_sub_k4();
    int lat; logic [31:0] r; logic c, o, z; bit to;
    do_op(1, 32'h05, 32'h05, 1'b0, 1'b1, 1, lat, r, c, o, z, to);
    checks++;
    if (to || lat !== 2) begin
      errors++;
      $display("FAIL sub_k4 latency: got %0d to=%0d, need 2", lat, to);
    end
    checks++;
    if ({r, c, o, z} !== {32'h00, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sub_k4 equal: r=%h c=%b o=%b z=%b, need 00 1 0 1", r, c, o, z);
    end
    do_op(1, 32'h03, 32'h05, 1'b1, 1'b1, 0, lat, r, c, o, z, to);
    checks++;
    if (to || {r, c, o, z} !== {32'hFE, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_k4 borrow: r=%h c=%b o=%b z=%b, need fe 0 0 0", r, c, o, z);
    end
  endtask

  task automatic test_full_width();
    int lat; logic [31:0] r; logic c, o, z; bit to;
    do_op(2, 32'hFFFF, 32'h0000, 1'b1, 1'b0, 0, lat, r, c, o, z, to);
    checks++;
    if (to || lat !== 1) begin
      errors++;
      $display("FAIL full_width latency: got %0d to=%0d, need 1", lat, to);
    end
    checks++;
    if ({r, c, o, z} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL full_width value: r=%h c=%b o=%b z=%b, need 0 1 0 1", r, c, o, z);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    a_d = 32'h40; b_d = 32'h41; cin_d = 1'b0; sub_d = 1'b0;
    iv[4] = 1'b1;
    @(posedge clk); #1;
    iv[4] = 1'b0;
    lat = 0;
    while (!ovl[4] && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL bp latency: got %0d, need 4", lat);
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({ovl[4], ir[4], res_w[4], co[4], of[4], zf[4]} !==
          {1'b1, 1'b0, 32'h81, 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL bp hold[%0d]: vld=%b rdy=%b r=%h c=%b o=%b z=%b, need 1 0 81 0 1 0",
                 k, ovl[4], ir[4], res_w[4], co[4], of[4], zf[4]);
      end
      @(posedge clk); #1;
    end
    ordy[4] = 1'b1;
    a_d = 32'h01; b_d = 32'h02; iv[4] = 1'b1;
    @(posedge clk); #1;
    ordy[4] = 1'b0;
    checks++;
    if (ir[4] !== 1'b1 || ovl[4] !== 1'b0) begin
      errors++;
      $display("FAIL bp release: rdy=%b vld=%b, need 1 0", ir[4], ovl[4]);
    end
    @(posedge clk); #1;
    iv[4] = 1'b0;
    checks++;
    if (ir[4] !== 1'b0) begin
      errors++;
      $display("FAIL b2b accept: rdy=%b, need 0", ir[4]);
    end
    lat = 0;
    while (!ovl[4] && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat !== 4 || res_w[4] !== 32'h03) begin
      errors++;
      $display("FAIL b2b result: lat=%0d r=%h, need 4 03", lat, res_w[4]);
    end
    ordy[4] = 1'b1;
    @(posedge clk); #1;
    ordy[4] = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int lat; int seen; logic [31:0] r; logic c, o, z; bit to;
    a_d = 32'hFF; b_d = 32'h00; cin_d = 1'b0; sub_d = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ir[0], ovl[0], res_w[0], co[0], of[0], zf[0]} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b vld=%b r=%h c=%b o=%b z=%b, need 1 0 0 0 0 0",
               ir[0], ovl[0], res_w[0], co[0], of[0], zf[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (ovl[0]) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_reset pulse: out_valid seen %0d cycles, need 0", seen);
    end
    do_op(0, 32'h10, 32'h20, 1'b0, 1'b0, 0, lat, r, c, o, z, to);
    checks++;
    if (to || lat !== 8 || r !== 32'h30) begin
      errors++;
      $display("FAIL mid_reset fresh: lat=%0d r=%h, need 8 30", lat, r);
    end
  endtask

  task automatic test_random(input int i);
    int w, n, lat; logic [31:0] r; logic c, o, z; bit to;
    longint unsigned mask, ea, eb, er, s;
    logic av_c, su, ec, eo, am, bm, rm;
    w = wof[i];
    n = w / kof[i];
    mask = (64'd1 << w) - 64'd1;
    for (int t = 0; t < 1000; t++) begin
      ea = longint'($urandom) & mask;
      eb = longint'($urandom) & mask;
      av_c = 1'($urandom_range(0, 1));
      su = 1'($urandom_range(0, 1));
      do_op(i, 32'(ea), 32'(eb), av_c, su, $urandom_range(0, 3),
            lat, r, c, o, z, to);
      am = 1'((ea >> (w - 1)) & 1);
      bm = 1'((eb >> (w - 1)) & 1);
      if (su) begin
        er = (ea - eb) & mask;
        ec = (ea >= eb);
        rm = 1'((er >> (w - 1)) & 1);
        eo = (am != bm) && (rm != am);
      end else begin
        s = ea + eb + longint'(av_c);
        er = s & mask;
        ec = 1'((s >> w) & 1);
        rm = 1'((er >> (w - 1)) & 1);
        eo = (am == bm) && (rm != am);
      end
      checks++;
      if (to || lat !== n) begin
        errors++;
        $display("FAIL rnd[%0d] latency: got %0d to=%0d, need %0d", i, lat, to, n);
      end
      checks++;
      if (r !== 32'(er)) begin
        errors++;
        $display("FAIL rnd[%0d] result: a=%h b=%h cin=%b sub=%b got %h need %h",
                 i, ea, eb, av_c, su, r, 32'(er));
      end
      checks++;
      if ({c, o, z} !== {ec, eo, (er == 0)}) begin
        errors++;
        $display("FAIL rnd[%0d] flags: a=%h b=%h sub=%b got c%b o%b z%b need c%b o%b z%b",
                 i, ea, eb, su, c, o, z, ec, eo, (er == 0));
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_add_k1();
    test_sub_k4();
    test_full_width();
    test_back_to_back();
    test_reset_mid_run();
    for (int i = 0; i < 4; i++) test_random(i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
